bus_trace_capture: RTL

Parametrised CPU bus-cycle logic analyser. It is the successor to the free-running 11-bit trace pin output on the 65C02 system top level. It records one entry per qualified bus cycle {sync, rnw, addr, data} into a circular on-chip buffer, with a programmable address/mask trigger and a post-trigger count. The frozen capture is then read out oldest-first over a simple request/valid port, e.g. for a UART dump by the monitor.

---
 rtl/bus_trace_pkg.sv | 30 +++
 rtl/trace_dpram.sv | 39 +++
 rtl/bus_trace_capture.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/bus_trace_pkg.sv
// Shared definitions for the bus-cycle trace capture block: capture states and
// the bit layout of one stored entry {sync, rnw, addr, data}.
package bus_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int unsigned DATA_LSB = 0;

    function automatic int unsigned addr_lsb(input int unsigned data_w);
        return data_w;
    endfunction

    function automatic int unsigned rnw_bit(input int unsigned addr_w, input int unsigned data_w);
        return addr_w + data_w;
    endfunction

    function automatic int unsigned sync_bit(input int unsigned addr_w, input int unsigned data_w);
        return addr_w + data_w + 1;
    endfunction

    function automatic int unsigned entry_w(input int unsigned addr_w, input int unsigned data_w);
        return addr_w + data_w + 2;
    endfunction

endpackage

// File: rtl/trace_dpram.sv
// Trace buffer storage: one write port, one synchronous read port with read
// enable so the read register holds its last value between reads.
module trace_dpram #(
    parameter int unsigned DEPTH_LOG2 = 9,
    parameter int unsigned WIDTH      = 26
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic                  re_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [WIDTH-1:0]      rdata_o
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Only the read register is reset; the array contents are don't-care until written.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_trace_capture.sv
// CPU bus-cycle logic analyser: circular pre-trigger history, address/mask
// trigger, post-trigger count, then oldest-first readout of the frozen buffer.
module bus_trace_capture
    import bus_trace_pkg::*;
#(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned DEPTH_LOG2 = 9
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clken,
    input  logic [ADDR_W-1:0]          bus_addr,
    input  logic [DATA_W-1:0]          bus_data,
    input  logic                       bus_rnw,
    input  logic                       bus_sync,
    input  logic                       arm,
    input  logic                       trig_force,
    input  logic [ADDR_W-1:0]          trig_addr,
    input  logic [ADDR_W-1:0]          trig_mask,
    input  logic                       trig_sync_only,
    input  logic [DEPTH_LOG2:0]        post_count,
    input  logic                       rd_req,
    output logic                       rd_valid,
    output logic [ADDR_W+DATA_W+1:0]   rd_data,
    output logic                       rd_empty,
    output logic                       armed,
    output logic                       triggered,
    output logic                       done,
    output logic [DEPTH_LOG2:0]        fill,
    output logic [DEPTH_LOG2-1:0]      trig_pos
);

    localparam int unsigned DEPTH    = 2 ** DEPTH_LOG2;
    localparam int unsigned CNT_W    = DEPTH_LOG2 + 1;
    localparam int unsigned ENTRY_W  = entry_w(ADDR_W, DATA_W);
    localparam int unsigned ADDR_LSB = addr_lsb(DATA_W);
    localparam int unsigned RNW_BIT  = rnw_bit(ADDR_W, DATA_W);
    localparam int unsigned SYNC_BIT = sync_bit(ADDR_W, DATA_W);

    state_e                state_q, state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2-1:0] trig_pos_q, trig_pos_d;
    logic [DEPTH_LOG2-1:0] post_eff_q, post_eff_d;
    logic [DEPTH_LOG2-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0]      fill_q, fill_d;
    logic [CNT_W-1:0]      rd_count_q, rd_count_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  rd_empty_q, rd_empty_d;
    logic                  armed_q, armed_d;
    logic                  triggered_q, triggered_d;
    logic                  done_q, done_d;

    logic                  match_c;
    logic                  we_c;
    logic                  re_c;
    logic [ENTRY_W-1:0]    wdata_c;
    logic [DEPTH_LOG2-1:0] post_clamp_c;
    logic [DEPTH_LOG2-1:0] fin_pe_c;
    logic [DEPTH_LOG2-1:0] wr_ptr_inc_c;
    logic [CNT_W-1:0]      fill_inc_c;
    logic [DEPTH_LOG2-1:0] fin_rd_ptr_c;
    logic [DEPTH_LOG2-1:0] fin_trig_pos_c;

    assign match_c = ((((bus_addr ^ trig_addr) & trig_mask) == '0)
                      && (!trig_sync_only || bus_sync)) || trig_force;

    // Post-trigger count can never exceed DEPTH-1 or the trigger entry would be overwritten.
    assign post_clamp_c = post_count[DEPTH_LOG2] ? '1 : post_count[DEPTH_LOG2-1:0];
    assign fin_pe_c     = (state_q == ST_POST) ? post_eff_q : post_clamp_c;
    assign wr_ptr_inc_c = wr_ptr_q + DEPTH_LOG2'(1);
    assign fill_inc_c   = (fill_q == CNT_W'(DEPTH)) ? fill_q : fill_q + CNT_W'(1);

    // Values latched on entry into DONE, computed from the post-write pointer and fill.
    assign fin_rd_ptr_c   = wr_ptr_inc_c - DEPTH_LOG2'(fill_inc_c);
    assign fin_trig_pos_c = DEPTH_LOG2'(fill_inc_c - CNT_W'(1) - CNT_W'(fin_pe_c));

    always_comb begin
        wdata_c                       = '0;
        wdata_c[DATA_LSB +: DATA_W]   = bus_data;
        wdata_c[ADDR_LSB +: ADDR_W]   = bus_addr;
        wdata_c[RNW_BIT]              = bus_rnw;
        wdata_c[SYNC_BIT]             = bus_sync;
    end

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        trig_pos_d  = trig_pos_q;
        post_eff_d  = post_eff_q;
        remaining_d = remaining_q;
        fill_d      = fill_q;
        rd_count_d  = rd_count_q;
        rd_valid_d  = 1'b0;
        we_c        = 1'b0;
        re_c        = 1'b0;

        if (arm) begin
            state_d    = ST_ARMED;
            wr_ptr_d   = '0;
            fill_d     = '0;
            rd_count_d = '0;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (clken) begin
                        we_c     = 1'b1;
                        wr_ptr_d = wr_ptr_inc_c;
                        fill_d   = fill_inc_c;
                        if (match_c) begin
                            post_eff_d = post_clamp_c;
                            if (post_clamp_c == '0) begin
                                state_d    = ST_DONE;
                                rd_ptr_d   = fin_rd_ptr_c;
                                rd_count_d = fill_inc_c;
                                trig_pos_d = fin_trig_pos_c;
                            end else begin
                                state_d     = ST_POST;
                                remaining_d = post_clamp_c;
                            end
                        end
                    end
                end
                ST_POST: begin
                    if (clken) begin
                        we_c        = 1'b1;
                        wr_ptr_d    = wr_ptr_inc_c;
                        fill_d      = fill_inc_c;
                        remaining_d = remaining_q - DEPTH_LOG2'(1);
                        if (remaining_q == DEPTH_LOG2'(1)) begin
                            state_d    = ST_DONE;
                            rd_ptr_d   = fin_rd_ptr_c;
                            rd_count_d = fill_inc_c;
                            trig_pos_d = fin_trig_pos_c;
                        end
                    end
                end
                ST_DONE: begin
                    if (rd_req && (rd_count_q != '0)) begin
                        re_c       = 1'b1;
                        rd_ptr_d   = rd_ptr_q + DEPTH_LOG2'(1);
                        rd_count_d = rd_count_q - CNT_W'(1);
                        rd_valid_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end

        armed_d     = (state_d == ST_ARMED);
        triggered_d = (state_d == ST_POST) || (state_d == ST_DONE);
        done_d      = (state_d == ST_DONE);
        rd_empty_d  = (rd_count_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            trig_pos_q  <= '0;
            post_eff_q  <= '0;
            remaining_q <= '0;
            fill_q      <= '0;
            rd_count_q  <= '0;
            rd_valid_q  <= 1'b0;
            rd_empty_q  <= 1'b1;
            armed_q     <= 1'b0;
            triggered_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            trig_pos_q  <= trig_pos_d;
            post_eff_q  <= post_eff_d;
            remaining_q <= remaining_d;
            fill_q      <= fill_d;
            rd_count_q  <= rd_count_d;
            rd_valid_q  <= rd_valid_d;
            rd_empty_q  <= rd_empty_d;
            armed_q     <= armed_d;
            triggered_q <= triggered_d;
            done_q      <= done_d;
        end
    end

    trace_dpram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (ENTRY_W)
    ) u_ram (
        .clk_i   (clk),
        .reset_i (reset),
        .we_i    (we_c),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata_c),
        .re_i    (re_c),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    assign rd_valid  = rd_valid_q;
    assign rd_empty  = rd_empty_q;
    assign armed     = armed_q;
    assign triggered = triggered_q;
    assign done      = done_q;
    assign fill      = fill_q;
    assign trig_pos  = trig_pos_q;

endmodule
